// File: rtl/ibex_obi_mem_responder.sv
// ibex_obi_mem_responder
// Memory responder for one request/grant/rvalid port of the traced core.
// It grants requests up to an outstanding limit, with optional injected
// stalls. Reads and byte-enabled writes are served from a word array.
// Responses return in order after a fixed latency. Addresses in the error
// window or beyond the array get error responses.
// Optional feature: define IBEX_OBI_RESP_CHECK_EN to compile in the
// protocol monitor that drives proto_err_o. Without it, proto_err_o is 0.
module ibex_obi_mem_responder #(
    parameter int          MemDepthWords  = 1024,
    parameter int          RespLatency    = 1,
    parameter int          MaxOutstanding = 2,
    parameter logic [31:0] ErrAddrBase    = 32'hF000_0000,
    parameter logic [31:0] ErrAddrMask    = 32'hF000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        proto_err_o
);

    localparam int              IdxW   = $clog2(MemDepthWords);
    localparam int              CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [31:0]     DepthW = 32'(MemDepthWords);

    // Word storage. It has no reset, so its contents survive rst_ni.
    logic [31:0]            r_mem [MemDepthWords];

    // Response pipeline. Stage 0 is loaded at accept.
    // The last stage drives the outputs.
    logic [RespLatency-1:0] r_pipe_valid;
    logic [RespLatency-1:0] r_pipe_err;
    logic [31:0]            r_pipe_rdata [RespLatency];

    logic [CntW-1:0]        r_outstanding;

    logic                   w_accept;
    logic                   w_in_err_win;
    logic                   w_out_of_range;
    logic                   w_err;
    logic                   w_wr_en;
    logic [IdxW-1:0]        w_idx;
    logic [31:0]            w_resp_rdata;

    // A retiring response frees its slot only one cycle later, because the
    // grant rule looks at the registered count.
    assign gnt_o          = req_i & ~stall_i & (r_outstanding < MaxCnt);
    assign w_accept       = req_i & gnt_o;
    assign w_in_err_win   = ((addr_i & ErrAddrMask) == ErrAddrBase);
    assign w_out_of_range = ({2'b00, addr_i[31:2]} >= DepthW);
    assign w_err          = w_in_err_win | w_out_of_range;
    assign w_wr_en        = w_accept & we_i & ~w_err;
    assign w_idx          = addr_i[IdxW+1:2];

    // Read data for the accepted request.
    // It is zero for writes, errors and idle cycles.
    // The array read sees the value from before any same-edge write.
    always_comb begin
        w_resp_rdata = 32'h0000_0000;
        if (w_accept && !we_i && !w_err) begin
            w_resp_rdata = r_mem[w_idx];
        end else begin
            w_resp_rdata = 32'h0000_0000;
        end
    end

    // Byte-enabled write into the word array at the accept edge.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (w_wr_en && be_i[k]) begin
                r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    // Fixed-latency response shift register.
    // Reset drops all in-flight responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pipe_valid <= {RespLatency{1'b0}};
            r_pipe_err   <= {RespLatency{1'b0}};
            for (int i = 0; i < RespLatency; i++) begin
                r_pipe_rdata[i] <= 32'h0000_0000;
            end
        end else begin
            r_pipe_valid[0] <= w_accept;
            r_pipe_err[0]   <= w_accept & w_err;
            r_pipe_rdata[0] <= w_resp_rdata;
            for (int i = 1; i < RespLatency; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_err[i]   <= r_pipe_err[i-1];
                r_pipe_rdata[i] <= r_pipe_rdata[i-1];
            end
        end
    end

    // Count of accepted requests whose response has not yet been presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= {CntW{1'b0}};
        end else begin
            case ({w_accept, rvalid_o})
                2'b10:   r_outstanding <= r_outstanding + CntOne;
                2'b01:   r_outstanding <= r_outstanding - CntOne;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign rvalid_o = r_pipe_valid[RespLatency-1];
    assign err_o    = r_pipe_err[RespLatency-1];
    assign rdata_o  = r_pipe_rdata[RespLatency-1];

`ifdef IBEX_OBI_RESP_CHECK_EN
    logic        r_pend;
    logic        r_we_q;
    logic [3:0]  r_be_q;
    logic [31:0] r_addr_q;
    logic [31:0] r_wdata_q;
    logic        r_proto_err;
    logic        w_hold_broken;
    logic        w_zero_be_write;
    logic        w_violation;

    // A request that was left ungranted must stay asserted and unchanged.
    assign w_hold_broken   = r_pend & (~req_i | (we_i != r_we_q) | (be_i != r_be_q) |
                                       (addr_i != r_addr_q) | (wdata_i != r_wdata_q));
    assign w_zero_be_write = req_i & we_i & (be_i == 4'h0);
    assign w_violation     = w_hold_broken | w_zero_be_write;

    // Remember the previous cycle's request, and whether it was left ungranted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend    <= 1'b0;
            r_we_q    <= 1'b0;
            r_be_q    <= 4'h0;
            r_addr_q  <= 32'h0000_0000;
            r_wdata_q <= 32'h0000_0000;
        end else begin
            r_pend    <= req_i & ~gnt_o;
            r_we_q    <= we_i;
            r_be_q    <= be_i;
            r_addr_q  <= addr_i;
            r_wdata_q <= wdata_i;
        end
    end

    // Sticky violation flag; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= r_proto_err | w_violation;
        end
    end

    // Report each violation together with the time it happened.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_violation) begin
            $error("ibex_obi_mem_responder: protocol violation at time %0t", $time);
        end
    end

    assign proto_err_o = r_proto_err;
`else
    assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_obi_mem_responder.sv
// Testbench for ibex_obi_mem_responder.
// It runs two instances: RespLatency=1 and RespLatency=3, both with
// MaxOutstanding=2. Each instance is checked every cycle against a calendar
// model. The model keeps the expected response in a slot indexed by the
// cycle in which it is due. Directed cases come first, then randomised traffic.
module tb_ibex_obi_mem_responder;

    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic        stall [2];
    logic [3:0]  be    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        gnt   [2];
    logic        rvalid[2];
    logic        err   [2];
    logic        proto [2];
    logic [31:0] rdata [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model state.
    logic [31:0] m_mem     [2][1024];
    logic        cal_v     [2][16];
    logic        cal_err   [2][16];
    logic [31:0] cal_rdata [2][16];
    logic        exp_proto [2];
    logic        p_pend    [2];
    logic        p_we      [2];
    logic [3:0]  p_be      [2];
    logic [31:0] p_addr    [2];
    logic [31:0] p_wdata   [2];
    logic        granted   [2];
    logic        gnt_seen  [2];
    logic        rv_now    [2];
    logic        holding   [2];
    logic [31:0] last_rdata[2];
    logic        last_err  [2];
    int          last_rv_cyc[2];
    int          rv_seen   [2];

    ibex_obi_mem_responder #(.RespLatency(1), .MaxOutstanding(MAX_OUT)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]),
        .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .stall_i(stall[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]), .proto_err_o(proto[0])
    );

    ibex_obi_mem_responder #(.RespLatency(3), .MaxOutstanding(MAX_OUT)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]),
        .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .stall_i(stall[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]), .proto_err_o(proto[1])
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle of checking and model update for instance d, sampled at negedge.
    task automatic model_cycle(input int d);
        int          slot;
        int          outst;
        int          due;
        logic        exp_gnt;
        logic        e;
        logic        viol;
        logic [31:0] rd;
        logic [9:0]  idx;
        slot  = cyc % 16;
        outst = 0;
        if (!rst_n) begin
            for (int s = 0; s < 16; s++) cal_v[d][s] = 1'b0;
            exp_proto[d] = 1'b0;
            p_pend[d]    = 1'b0;
            granted[d]   = 1'b0;
            rv_now[d]    = rvalid[d];
            gnt_seen[d]  = gnt[d];
            check_eq("rst_rvalid", rvalid[d], 1'b0);
            check_eq("rst_rdata", rdata[d], 32'h0);
            check_eq("rst_err", err[d], 1'b0);
            check_eq("rst_proto", proto[d], 1'b0);
            check_eq("rst_gnt", gnt[d], req[d] & ~stall[d]);
            return;
        end
        for (int k = 0; k <= 8; k++) outst += int'(cal_v[d][(cyc + k) % 16]);
        exp_gnt = req[d] && !stall[d] && (outst < MAX_OUT);
        check_eq("gnt", gnt[d], exp_gnt);
        gnt_seen[d] = gnt[d];
        rv_now[d]   = rvalid[d];
        check_eq("rvalid", rvalid[d], cal_v[d][slot]);
        if (cal_v[d][slot]) begin
            check_eq("resp_err", err[d], cal_err[d][slot]);
            check_eq("resp_rdata", rdata[d], cal_rdata[d][slot]);
        end
        if (rvalid[d]) begin
            last_rdata[d]  = rdata[d];
            last_err[d]    = err[d];
            last_rv_cyc[d] = cyc;
            rv_seen[d]++;
        end
        cal_v[d][slot] = 1'b0;
        check_eq("proto", proto[d], exp_proto[d]);
`ifdef IBEX_OBI_RESP_CHECK_EN
        viol = (p_pend[d] && (!req[d] || we[d] !== p_we[d] || be[d] !== p_be[d] ||
                addr[d] !== p_addr[d] || wdata[d] !== p_wdata[d])) ||
               (req[d] && we[d] && be[d] == 4'h0);
        if (viol) exp_proto[d] = 1'b1;
        p_pend[d]  = req[d] && !exp_gnt;
        p_we[d]    = we[d];
        p_be[d]    = be[d];
        p_addr[d]  = addr[d];
        p_wdata[d] = wdata[d];
`else
        viol = 1'b0;
        p_pend[d] = viol;
`endif
        granted[d] = exp_gnt;
        if (exp_gnt) begin
            e   = ((addr[d] & 32'hF000_0000) == 32'hF000_0000) || (addr[d][31:2] >= 30'd1024);
            idx = addr[d][11:2];
            rd  = 32'h0;
            if (!e && !we[d]) rd = m_mem[d][idx];
            if (!e && we[d]) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[d][k]) m_mem[d][idx][8*k +: 8] = wdata[d][8*k +: 8];
                end
            end
            due = (cyc + lat_of(d)) % 16;
            cal_v[d][due]     = 1'b1;
            cal_err[d][due]   = e;
            cal_rdata[d][due] = rd;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) model_cycle(d);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a request on instance d and hold it until granted (bounded).
    task automatic do_req(input int d, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] wd, output int gcyc);
        int c;
        req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
        gcyc = -1;
        for (int i = 0; i < 50; i++) begin
            c = cyc;
            tick();
            if (granted[d]) begin
                gcyc = c;
                break;
            end
        end
        if (gcyc < 0) check_eq("grant_timeout", granted[d], 1'b1);
        req[d] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(99);
        if (sel < 70)      return {26'd0, 4'($urandom_range(15)), 2'($urandom_range(3))};
        else if (sel < 80) return 32'hF000_0000 | 32'($urandom_range(32'h0FFF_FFFF));
        else if (sel < 90) return 32'h0000_1000 + 32'($urandom_range(32'h0000_FFFF));
        else               return {20'd0, 10'($urandom_range(1023)), 2'b00};
    endfunction

    // Directed cases, then random traffic, then the summary.
    initial begin
        int         g;
        logic [7:0] g_pat;
        logic [7:0] r_pat;
        logic       gs;
        int         rv0;
        logic       ga;
        logic       gb;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 1024; w++) m_mem[d][w] = 32'h0;
            for (int s = 0; s < 16; s++) begin
                cal_v[d][s] = 1'b0; cal_err[d][s] = 1'b0; cal_rdata[d][s] = 32'h0;
            end
            req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
            stall[d] = 1'b0; exp_proto[d] = 1'b0; p_pend[d] = 1'b0; holding[d] = 1'b0;
            rv_seen[d] = 0; last_rv_cyc[d] = -1;
        end
        rst_n = 1'b0;
        req[0] = 1'b1; addr[0] = 32'h10;
        idle(2);
        req[0] = 1'b0;
        rst_n = 1'b1;

        // Full-word write, then read back at latency 1.
        do_req(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, g);
        do_req(0, 1'b0, 4'hF, 32'h10, 32'h0, g);
        tick();
        check_eq("rd_lat", last_rv_cyc[0], g + 1);
        check_eq("rd_data", last_rdata[0], 32'hDEAD_BEEF);
        check_eq("rd_err", last_err[0], 1'b0);

        // Partial byte enables over zero memory.
        do_req(0, 1'b1, 4'b0101, 32'h20, 32'h1122_3344, g);
        do_req(0, 1'b0, 4'h0, 32'h20, 32'h0, g);
        tick();
        check_eq("be_data", last_rdata[0], 32'h0022_0044);

        // Error window, out of range, and a suppressed write.
        do_req(0, 1'b0, 4'hF, 32'hF000_0004, 32'h0, g);
        tick();
        check_eq("win_err", last_err[0], 1'b1);
        check_eq("win_rdata", last_rdata[0], 32'h0);
        do_req(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, g);
        tick();
        check_eq("oor_err", last_err[0], 1'b1);
        check_eq("oor_rdata", last_rdata[0], 32'h0);
        do_req(0, 1'b1, 4'hF, 32'hF000_0004, 32'hFFFF_FFFF, g);
        do_req(0, 1'b0, 4'hF, 32'h0000_0004, 32'h0, g);
        tick();
        check_eq("supp_data", last_rdata[0], 32'h0);
        check_eq("supp_err", last_err[0], 1'b0);

        // Throughput limit: latency 3, two outstanding.
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h10;
        g_pat = 8'h0; r_pat = 8'h0;
        for (int i = 0; i < 8; i++) begin
            tick();
            g_pat[i] = gnt_seen[1];
            r_pat[i] = rv_now[1];
        end
        req[1] = 1'b0;
        check_eq("thr_gnt", g_pat, 8'h33);
        check_eq("thr_rvalid", r_pat, 8'h98);
        idle(10);

        // Stall with a stable held request.
        req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h20; stall[0] = 1'b1;
        gs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            gs = gs | gnt_seen[0];
        end
        check_eq("stall_gnt", gs, 1'b0);
        stall[0] = 1'b0;
        tick();
        check_eq("stall_release", gnt_seen[0], 1'b1);
        req[0] = 1'b0;
        idle(2);
        check_eq("stall_proto", proto[0], 1'b0);

`ifdef IBEX_OBI_RESP_CHECK_EN
        // Change the address while the request is ungranted under stall.
        req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h30; stall[0] = 1'b1;
        tick();
        addr[0] = 32'h34;
        tick();
        check_eq("proto_set", proto[0], 1'b1);
        idle(3);
        check_eq("proto_sticky", proto[0], 1'b1);
        stall[0] = 1'b0;
        tick();
        req[0] = 1'b0;
        idle(3);
`endif

        // Reset while two responses are in flight.
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h10;
        idle(2);
        req[1] = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rv0 = rv_seen[1];
        idle(6);
        check_eq("rst_no_rvalid", 32'(rv_seen[1] - rv0), 32'h0);
        check_eq("rst_proto_clr", proto[0], 1'b0);
        req[1] = 1'b1;
        tick();
        ga = gnt_seen[1];
        tick();
        gb = gnt_seen[1];
        req[1] = 1'b0;
        check_eq("rst_cnt_zero", {ga, gb}, 2'b11);
        idle(6);

        // Randomised traffic on both instances.
        for (int i = 0; i < 2500; i++) begin
            for (int d = 0; d < 2; d++) begin
                if (!holding[d]) begin
                    if ($urandom_range(99) < 60) begin
                        holding[d] = 1'b1;
                        req[d]     = 1'b1;
                        we[d]      = 1'($urandom_range(1));
                        be[d]      = we[d] ? 4'($urandom_range(1, 15)) : 4'($urandom_range(15));
                        addr[d]    = rand_addr();
                        wdata[d]   = $urandom;
                    end else begin
                        req[d] = 1'b0;
                    end
                end
                stall[d] = ($urandom_range(99) < 20);
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                if (granted[d]) holding[d] = 1'b0;
            end
        end
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0;
            stall[d] = 1'b0;
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
